// File: rtl/cpld_pkg.sv
// Shared CPLD definitions: refresh state encoding and the default DRAM strobe
// timing used by both the refresh executor and the RAM strobe generator.
package cpld_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAS  = 2'd1,
        RAS  = 2'd2,
        PRE  = 2'd3
    } refState_t;

    // Default DRAM timing in CLK cycles: tCSR, tRAS, tRP, and the phase counter width.
    localparam int REF_CSR_CYC = 1;
    localparam int REF_RAS_CYC = 3;
    localparam int REF_PRE_CYC = 2;
    localparam int REF_CNTW    = 3;

    localparam logic [7:0] MISS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/dram_refresh_exec.sv
// Refresh executor: owes one CAS-before-RAS refresh per RefReq window and runs it
// when RAM is idle, or stalls new CPU RAM cycles once the request turns urgent.
module dram_refresh_exec
    import cpld_pkg::*;
#(
    parameter int CSR_CYC = REF_CSR_CYC,
    parameter int RAS_CYC = REF_RAS_CYC,
    parameter int PRE_CYC = REF_PRE_CYC,
    parameter int CNTW    = REF_CNTW
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RefReq,
    input  logic       RefUrg,
    input  logic       BACT,
    input  logic       RAMCS,
    input  logic       RAMBusy,
    output logic       RAMHold,
    output logic       RefRAS,
    output logic       RefCAS,
    output logic       RefBusy,
    output logic       RefMiss,
    output logic [7:0] MissCnt
);

    localparam logic [CNTW-1:0] CSR_LOAD = CNTW'(CSR_CYC - 1);
    localparam logic [CNTW-1:0] RAS_LOAD = CNTW'(RAS_CYC - 1);
    localparam logic [CNTW-1:0] PRE_LOAD = CNTW'(PRE_CYC - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    refState_t       state;
    logic [CNTW-1:0] phaseCnt;
    logic            done;
    logic            refReqr;

    logic pending;
    logic startRef;
    logic cntZero;
    logic enterPre;
    logic missCond;

    // The CPU wins a same-cycle tie unless the hold is already stalling it.
    assign pending  = RefReq && !done;
    assign startRef = (state == IDLE) && pending && !RAMBusy && (RAMHold || !(BACT && RAMCS));
    assign cntZero  = (phaseCnt == '0);
    assign enterPre = (state == RAS) && cntZero;
    assign missCond = refReqr && !RefReq && !done && (state == IDLE);

    // Strobes follow the state one cycle late, so each phase shows on the pins for its full length.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            phaseCnt <= '0;
            RefCAS   <= 1'b0;
            RefRAS   <= 1'b0;
            RefBusy  <= 1'b0;
        end else begin
            RefCAS <= (state == CAS) || (state == RAS);
            RefRAS <= (state == RAS);
            case (state)
                IDLE: begin
                    if (startRef) begin
                        state    <= CAS;
                        phaseCnt <= CSR_LOAD;
                        RefBusy  <= 1'b1;
                    end
                end
                CAS: begin
                    if (cntZero) begin
                        state    <= RAS;
                        phaseCnt <= RAS_LOAD;
                    end else begin
                        phaseCnt <= phaseCnt - CNT_ONE;
                    end
                end
                RAS: begin
                    if (cntZero) begin
                        state    <= PRE;
                        phaseCnt <= PRE_LOAD;
                    end else begin
                        phaseCnt <= phaseCnt - CNT_ONE;
                    end
                end
                PRE: begin
                    if (cntZero) begin
                        state   <= IDLE;
                        RefBusy <= 1'b0;
                    end else begin
                        phaseCnt <= phaseCnt - CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RefBusy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done    <= 1'b0;
            refReqr <= 1'b0;
        end else begin
            refReqr <= RefReq;
            if (!RefReq) begin
                done <= 1'b0;
            end else if (startRef) begin
                done <= 1'b1;
            end
        end
    end

    // Hold spans CAS and RAS; releasing at PRE lets the CPU overlap with precharge bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RAMHold <= 1'b0;
        end else if (!RefReq || enterPre) begin
            RAMHold <= 1'b0;
        end else if (pending && RefUrg) begin
            RAMHold <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RefMiss <= 1'b0;
            MissCnt <= '0;
        end else begin
            RefMiss <= missCond;
            if (missCond && (MissCnt != MISS_CNT_MAX)) begin
                MissCnt <= MissCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dram_refresh_exec.sv
// Directed bench for dram_refresh_exec: idle refresh, CPU contention, urgent stall,
// miss counting with saturation, window edge and asynchronous reset.
module tb_dram_refresh_exec;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RefReq, RefUrg, BACT, RAMCS, RAMBusy;
    logic       RAMHold, RefRAS, RefCAS, RefBusy, RefMiss;
    logic [7:0] MissCnt;

    int checkCount = 0;
    int errorCount = 0;

    dram_refresh_exec dut (
        .CLK     (CLK),
        .RST     (RST),
        .RefReq  (RefReq),
        .RefUrg  (RefUrg),
        .BACT    (BACT),
        .RAMCS   (RAMCS),
        .RAMBusy (RAMBusy),
        .RAMHold (RAMHold),
        .RefRAS  (RefRAS),
        .RefCAS  (RefCAS),
        .RefBusy (RefBusy),
        .RefMiss (RefMiss),
        .MissCnt (MissCnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic urg, input logic bact,
                                 input logic ramcs, input logic busy);
        RefReq  = req;
        RefUrg  = urg;
        BACT    = bact;
        RAMCS   = ramcs;
        RAMBusy = busy;
    endtask

    // Advance one clock and land 1 time unit after the edge, where outputs are stable.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected {RefBusy, RefCAS, RefRAS} after each edge following the triggering edge.
    logic [2:0] refTrace [0:8];

    initial begin
        refTrace[0] = 3'b100;
        refTrace[1] = 3'b110;
        refTrace[2] = 3'b111;
        refTrace[3] = 3'b111;
        refTrace[4] = 3'b111;
        refTrace[5] = 3'b100;
        refTrace[6] = 3'b000;
        refTrace[7] = 3'b000;
        refTrace[8] = 3'b000;

        RST = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        #12;
        checkOutput("reset RefCAS", RefCAS, 0);
        checkOutput("reset RefRAS", RefRAS, 0);
        checkOutput("reset RAMHold", RAMHold, 0);
        checkOutput("reset RefBusy", RefBusy, 0);
        checkOutput("reset MissCnt", MissCnt, 0);
        RST = 1'b0;
        step();

        $display("[TB] idle refresh");
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            checkOutput($sformatf("idle trace %0d", i), int'({RefBusy, RefCAS, RefRAS}), int'(refTrace[i]));
        end
        applyStimulus(0, 0, 0, 0, 0);
        step();
        checkOutput("idle no miss", RefMiss, 0);

        $display("[TB] cpu contention");
        applyStimulus(1, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("contend busy %0d", i), RefBusy, 0);
        end
        applyStimulus(1, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput($sformatf("cpu wins %0d", i), RefBusy, 0);
        end
        applyStimulus(1, 0, 0, 1, 0);
        step();
        checkOutput("contend start", RefBusy, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("contend hold %0d", i), RAMHold, 0);
        end
        checkOutput("contend end busy", RefBusy, 0);
        applyStimulus(0, 0, 0, 0, 0);
        step();

        $display("[TB] urgent stall");
        applyStimulus(1, 0, 1, 1, 1);
        step();
        step();
        checkOutput("urg hold before", RAMHold, 0);
        applyStimulus(1, 1, 1, 1, 1);
        step();
        checkOutput("urg hold rise", RAMHold, 1);
        checkOutput("urg no start", RefBusy, 0);
        step();
        step();
        checkOutput("urg stalled", RefBusy, 0);
        applyStimulus(1, 1, 1, 1, 0);
        step();
        checkOutput("urg start", RefBusy, 1);
        for (int i = 1; i <= 6; i++) begin
            step();
            checkOutput($sformatf("urg hold e%0d", i), RAMHold, (i <= 3) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        step();

        $display("[TB] miss");
        applyStimulus(1, 0, 1, 1, 1);
        step();
        step();
        step();
        applyStimulus(0, 0, 1, 1, 1);
        step();
        checkOutput("miss pulse", RefMiss, 1);
        checkOutput("miss count 1", MissCnt, 1);
        step();
        checkOutput("miss pulse end", RefMiss, 0);
        for (int w = 0; w < 299; w++) begin
            applyStimulus(1, 0, 1, 1, 1);
            step();
            step();
            applyStimulus(0, 0, 1, 1, 1);
            step();
        end
        checkOutput("miss saturate", MissCnt, 255);

        $display("[TB] window edge");
        applyStimulus(1, 0, 0, 0, 0);
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput($sformatf("edge no miss %0d", i), RefMiss, 0);
        end
        checkOutput("edge completed", RefBusy, 0);
        applyStimulus(1, 0, 0, 0, 0);
        step();
        checkOutput("edge restart busy", RefBusy, 1);
        step();
        checkOutput("edge restart CAS", RefCAS, 1);
        for (int i = 0; i < 6; i++) step();

        $display("[TB] async reset");
        applyStimulus(0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 1, 0, 0, 1);
        step();
        checkOutput("rst pre hold", RAMHold, 1);
        applyStimulus(1, 1, 0, 0, 0);
        step();
        step();
        step();
        checkOutput("rst pre RAS", RefRAS, 1);
        checkOutput("rst pre CAS", RefCAS, 1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rst RefRAS", RefRAS, 0);
        checkOutput("rst RefCAS", RefCAS, 0);
        checkOutput("rst RAMHold", RAMHold, 0);
        checkOutput("rst RefBusy", RefBusy, 0);
        checkOutput("rst MissCnt", MissCnt, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        RST = 1'b0;
        step();
        checkOutput("post rst idle", RefBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dram_refresh_exec.md
Name: dram_refresh_exec

Overview:
- Responder for the refresh-request pair (RefReq/RefUrg) produced by the E-clock timer block.
- Tracks one owed refresh per request window (about 14 us).
- Executes the refresh as a CAS-before-RAS cycle: opportunistically when RAM is idle, or by stalling new CPU RAM cycles once the request turns urgent.
- Sits between the timer block and the RAM strobe generator. Its RefRAS/RefCAS are ORed into the RAM controller's strobe outputs.

Parameters:
- CSR_CYC, 1: CLK cycles CAS is low before RAS falls (tCSR); minimum 1.
- RAS_CYC, 3: CLK cycles RAS and CAS are both low (tRAS); minimum 1.
- PRE_CYC, 2: CLK cycles of precharge after both strobes rise (tRP); minimum 1.
- CNTW, 3: width of the phase down-counter; must hold max(CSR_CYC, RAS_CYC, PRE_CYC).

Ports:
- CLK in 1: FSB clock; all logic on posedge.
- RST in 1: asynchronous, active-high reset.
- RefReq in 1: refresh window open; low for one E period between windows; synchronous to CLK.
- RefUrg in 1: refresh urgent, last two E periods of the window.
- BACT in 1: CPU bus cycle active.
- RAMCS in 1: current CPU cycle decodes to RAM.
- RAMBusy in 1: RAM controller has RAS/CAS asserted for a CPU cycle.
- RAMHold out 1: RAM controller must not start a new CPU RAM cycle.
- RefRAS out 1: refresh RAS, active-high.
- RefCAS out 1: refresh CAS, active-high.
- RefBusy out 1: high in any state other than IDLE.
- RefMiss out 1: one-cycle pulse, a window closed without a refresh.
- MissCnt out 8: saturating count of missed windows.

Behaviour:
- Reset (async): state=IDLE, Done=0, RefReqr=0, counter=0, all outputs 0, MissCnt=0. Strobes drop immediately even mid-refresh.
- RefReqr is a 1-cycle registered copy of RefReq. Pending = RefReq && !Done.
- Done is set on the IDLE->CAS transition. Done is cleared on any cycle with RefReq=0.
- States:
  - IDLE:
    - Go to CAS if Pending && !RAMBusy && (RAMHold || !(BACT && RAMCS)).
    - The CPU wins same-cycle contention unless RAMHold is already high.
  - CAS:
    - RefCAS=1, RefRAS=0. Counter loaded with CSR_CYC-1 on entry.
    - When the counter reaches 0, go to RAS and load RAS_CYC-1.
  - RAS:
    - RefCAS=1, RefRAS=1.
    - When the counter reaches 0, go to PRE and load PRE_CYC-1.
  - PRE:
    - Both strobes 0.
    - When the counter reaches 0, go to IDLE.
- Strobes are registered; they change the cycle after the state transition.
- Total refresh length = CSR_CYC+RAS_CYC+PRE_CYC cycles (6 at default).
- RAMHold (registered):
  - Set when Pending && RefUrg.
  - Cleared on entering PRE, or when RefReq=0.
  - Held through CAS and RAS.
  - Never set while Done=1.
- An active refresh always runs to completion, even if RefReq falls during it. Only RST aborts it.
- Miss detection:
  - When RefReqr=1 && RefReq=0 && Done=0 && state==IDLE, pulse RefMiss for 1 cycle.
  - MissCnt increments and saturates at 255 (no wrap).
- RefReq rising while Done=0 immediately makes a refresh Pending; there is no extra delay.
- RefUrg without RefReq is ignored.

Decomposition:
- Shared package cpld_pkg:
  - State encoding enum (IDLE=0, CAS=1, RAS=2, PRE=3).
  - Default timing constants, shared with the RAM strobe generator.
- Single module. The phase down-counter is inline; it does not justify a sub-module.

Test Plan:
- Idle refresh:
  - Stimulus: RefReq 0->1, BACT=0, RAMBusy=0.
  - Response: RefCAS high 2 cycles after the rise (1 for the transition, 1 for the registered strobe). RefRAS high 1 cycle later for 3 cycles. 2 precharge cycles, then IDLE. Exactly one refresh in that window.
- CPU contention:
  - Stimulus: RefReq=1, BACT=RAMCS=1, RAMBusy pulsed high for 4 cycles, RefUrg=0.
  - Response: no strobes until RAMBusy=0 and BACT=0. Refresh then starts, with RAMHold=0 throughout.
- Urgent stall:
  - Stimulus: back-to-back CPU RAM cycles and RefUrg=1.
  - Response: RAMHold rises the cycle after RefUrg. Refresh starts the first cycle RAMBusy=0 while RAMCS stays high. RAMHold falls on PRE entry.
- Miss:
  - Stimulus: hold RAMBusy=1 for an entire window, then drop RefReq.
  - Response: one RefMiss pulse and MissCnt=1. Repeat 300 windows and check MissCnt=255.
- Window edge:
  - Stimulus: RefReq falls during RAS.
  - Response: refresh completes, no RefMiss. On the next RefReq rise a new refresh occurs.
- Async reset:
  - Stimulus: assert RST mid-RAS.
  - Response: RefRAS/RefCAS/RAMHold are 0 before the next CLK edge. MissCnt=0, state IDLE.
